// File: rtl/rng_lfsr_core_if.sv
// rng_lfsr_core_if: control and data bundle between the AXI4-Lite register
// slave (master side) and the LFSR generation core (slave side).
// pop_count is present only when RNG_POP_COUNT_EN is defined.
interface rng_lfsr_core_if #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
);
    logic                          enable;
    logic                          seed_wr;
    logic [DATA_WIDTH-1:0]         seed_data;
    logic                          rd_en;
    logic [DATA_WIDTH-1:0]         rd_data;
    logic                          rd_valid;
    logic                          full;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          underflow;
    logic                          err_clr;
`ifdef RNG_POP_COUNT_EN
    logic [31:0]                   pop_count;
`endif

    modport master (
        output enable, seed_wr, seed_data, rd_en, err_clr,
`ifdef RNG_POP_COUNT_EN
        input  pop_count,
`endif
        input  rd_data, rd_valid, full, fifo_count, underflow
    );

    modport slave (
        input  enable, seed_wr, seed_data, rd_en, err_clr,
`ifdef RNG_POP_COUNT_EN
        output pop_count,
`endif
        output rd_data, rd_valid, full, fifo_count, underflow
    );
endinterface

// File: rtl/rng_lfsr_core.sv
// rng_lfsr_core: 32-bit Galois LFSR feeding a small first-word-fall-through
// FIFO. One word is generated per cycle while enabled and the FIFO has room
// (or is being popped). A seed write reloads the LFSR and flushes the FIFO.
// rd_data is a registered copy of the FIFO head so it never shows an
// unwritten storage entry. Define RNG_POP_COUNT_EN to add the pop counter.
module rng_lfsr_core #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    FIFO_DEPTH   = 4,
    parameter logic [DATA_WIDTH-1:0] TAPS         = 32'h80200003,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_SEED = 32'hACE12468
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    rng_lfsr_core_if.slave     bus
);
    localparam int             PW      = $clog2(FIFO_DEPTH);
    localparam int             CW      = PW + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] lfsr_q;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  underflow_q;

    logic                  push, pop, empty_pop;
    logic [DATA_WIDTH-1:0] lfsr_step;
    logic [CW-1:0]         count_after_pop, count_next;
    logic [PW-1:0]         rd_ptr_inc, wr_ptr_inc;
    logic [DATA_WIDTH-1:0] head_next;

    function automatic logic [DATA_WIDTH-1:0] lfsr_advance(input logic [DATA_WIDTH-1:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : '0);
    endfunction

    assign bus.rd_valid   = (count_q != '0);
    assign bus.full       = (count_q == DEPTH_C);
    assign bus.fifo_count = count_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.underflow  = underflow_q;

    // Datapath control: push/pop qualification, next count and next head word
    always_comb begin
        push            = bus.enable & ~bus.seed_wr & (~bus.full | bus.rd_en);
        pop             = bus.rd_en & bus.rd_valid & ~bus.seed_wr;
        empty_pop       = bus.rd_en & ~bus.rd_valid;
        lfsr_step       = lfsr_advance(lfsr_q);
        rd_ptr_inc      = rd_ptr_q + PW'(1);
        wr_ptr_inc      = wr_ptr_q + PW'(1);
        count_after_pop = count_q - CW'(pop);
        count_next      = bus.seed_wr ? '0 : (count_after_pop + CW'(push));
        // When the FIFO drains to nothing this cycle, the head is the word
        // being pushed right now; otherwise it is already in storage.
        head_next       = (count_after_pop == '0) ? lfsr_step
                                                  : mem[pop ? rd_ptr_inc : rd_ptr_q];
    end

    // FSM next state from enable and the post-update count
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.enable) state_d = (count_next == DEPTH_C) ? HOLD : FILL;
            FILL: begin
                if (!bus.enable)                state_d = IDLE;
                else if (count_next == DEPTH_C) state_d = HOLD;
            end
            HOLD: begin
                if (!bus.enable)               state_d = IDLE;
                else if (count_next < DEPTH_C) state_d = FILL;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // LFSR: seed load wins, otherwise step whenever a word is pushed
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)         lfsr_q <= DEFAULT_SEED;
        else if (bus.seed_wr) lfsr_q <= (bus.seed_data == '0) ? DEFAULT_SEED : bus.seed_data;
        else if (push)        lfsr_q <= lfsr_step;
    end

    // FIFO storage write; the pushed word is the post-step LFSR value
    always_ff @(posedge ACLK) begin
        if (push) mem[wr_ptr_q] <= lfsr_step;
    end

    // FIFO pointers, count and registered head word
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            count_q <= count_next;
            if (bus.seed_wr) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_inc;
                if (pop)  rd_ptr_q <= rd_ptr_inc;
                if (count_next != '0) rd_data_q <= head_next;
            end
        end
    end

    // Sticky underflow: an empty pop sets it and beats a same-cycle clear
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)         underflow_q <= 1'b0;
        else if (empty_pop)   underflow_q <= 1'b1;
        else if (bus.err_clr) underflow_q <= 1'b0;
    end

`ifdef RNG_POP_COUNT_EN
    logic [31:0] pop_count_q;
    assign bus.pop_count = pop_count_q;

    // Successful-pop counter, cleared by a seed load
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)         pop_count_q <= '0;
        else if (bus.seed_wr) pop_count_q <= '0;
        else if (pop)         pop_count_q <= pop_count_q + 32'd1;
    end
`endif

endmodule
